// File: rtl/if_stage_pkg.sv
// Shared constants and types for the instruction fetch stage: reset PC,
// bubble encoding, RISC-V major opcodes and the PC source selector.
package if_stage_pkg;

    localparam logic [31:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [31:0] NOP_INST_DEF = 32'h0000_0013;
    localparam int          IMEM_AW_DEF  = 14;

    localparam logic [6:0] OPC_LOAD   = 7'b000_0011;
    localparam logic [6:0] OPC_OP_IMM = 7'b001_0011;
    localparam logic [6:0] OPC_STORE  = 7'b010_0011;
    localparam logic [6:0] OPC_OP     = 7'b011_0011;
    localparam logic [6:0] OPC_BRANCH = 7'b110_0011;
    localparam logic [6:0] OPC_JALR   = 7'b110_0111;
    localparam logic [6:0] OPC_JAL    = 7'b110_1111;

    typedef enum logic [1:0] {
        PC_SEL_RESET    = 2'd0,
        PC_SEL_REDIRECT = 2'd1,
        PC_SEL_HOLD     = 2'd2,
        PC_SEL_SEQ      = 2'd3
    } pc_sel_e;

    // Instruction fetches are word aligned; low address bits are dropped.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_stage_pc_gen.sv
// PC register, next-PC selection and misaligned-redirect flag. The next PC
// also drives the instruction BRAM address so read data lines up with pc.
module pc_gen
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int          IMEM_AW  = IMEM_AW_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               pc_write,
    input  logic               redirect,
    input  logic [31:0]        redirect_pc,
    output logic [31:0]        pc,
    output logic [IMEM_AW-1:0] imem_addr,
    output logic               misaligned
);

    pc_sel_e     pc_sel_s;
    logic [31:0] pc_next_s;
    logic [31:0] pc_r;
    logic        misaligned_r;

    // Select the next-PC source in priority order.
    always_comb begin
        pc_sel_s = PC_SEL_SEQ;
        if (rst) begin
            pc_sel_s = PC_SEL_RESET;
        end else if (redirect) begin
            pc_sel_s = PC_SEL_REDIRECT;
        end else if (!pc_write) begin
            pc_sel_s = PC_SEL_HOLD;
        end else begin
            pc_sel_s = PC_SEL_SEQ;
        end
    end

    // Next-PC mux; sequential fetch wraps naturally at the top of memory.
    always_comb begin
        pc_next_s = pc_r;
        case (pc_sel_s)
            PC_SEL_RESET:    pc_next_s = RESET_PC;
            PC_SEL_REDIRECT: pc_next_s = word_align(redirect_pc);
            PC_SEL_HOLD:     pc_next_s = pc_r;
            PC_SEL_SEQ:      pc_next_s = pc_r + 32'd4;
            default:         pc_next_s = RESET_PC;
        endcase
    end

    // PC register and one-cycle misaligned-target pulse.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_r         <= RESET_PC;
            misaligned_r <= 1'b0;
        end else begin
            pc_r         <= pc_next_s;
            misaligned_r <= redirect & (|redirect_pc[1:0]);
        end
    end

    assign pc         = pc_r;
    assign imem_addr  = pc_next_s[IMEM_AW+1:2];
    assign misaligned = misaligned_r;

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage with IF/ID pipeline register and fetch counter.
// Redirects flush the wrong-path fetch with a NOP bubble and win over stalls.
module if_stage
    import if_stage_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter logic [31:0] NOP_INST = NOP_INST_DEF,
    parameter int          IMEM_AW  = IMEM_AW_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               PcWrite,
    input  logic               IF_ID_Write,
    input  logic               Redirect,
    input  logic [31:0]        RedirectPc,
    output logic [IMEM_AW-1:0] ImemAddr,
    input  logic [31:0]        ImemData,
    output logic [31:0]        Inst,
    output logic [31:0]        PcOut,
    output logic               InstValid,
    output logic               Misaligned,
    output logic [31:0]        FetchCount
);

    logic [31:0] pc_s;
    logic [31:0] inst_r;
    logic [31:0] pc_out_r;
    logic        inst_valid_r;
    logic [31:0] fetch_count_r;

    pc_gen #(
        .RESET_PC (RESET_PC),
        .IMEM_AW  (IMEM_AW)
    ) u_pc_gen (
        .clk         (clk),
        .rst         (rst),
        .pc_write    (PcWrite),
        .redirect    (Redirect),
        .redirect_pc (RedirectPc),
        .pc          (pc_s),
        .imem_addr   (ImemAddr),
        .misaligned  (Misaligned)
    );

    // IF/ID register: reset, flush on redirect, hold on stall, else load.
    always_ff @(posedge clk) begin
        if (rst) begin
            inst_r        <= NOP_INST;
            pc_out_r      <= 32'h0000_0000;
            inst_valid_r  <= 1'b0;
            fetch_count_r <= 32'd0;
        end else if (Redirect) begin
            inst_r        <= NOP_INST;
            pc_out_r      <= pc_s;
            inst_valid_r  <= 1'b0;
            fetch_count_r <= fetch_count_r;
        end else if (!IF_ID_Write) begin
            inst_r        <= inst_r;
            pc_out_r      <= pc_out_r;
            inst_valid_r  <= inst_valid_r;
            fetch_count_r <= fetch_count_r;
        end else begin
            inst_r        <= ImemData;
            pc_out_r      <= pc_s;
            inst_valid_r  <= 1'b1;
            fetch_count_r <= fetch_count_r + 32'd1;
        end
    end

    assign Inst       = inst_r;
    assign PcOut      = pc_out_r;
    assign InstValid  = inst_valid_r;
    assign FetchCount = fetch_count_r;

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction Fetch stage plus IF/ID pipeline register; feeds Inst/PcIn of the decode stage.
- Owns the PC and drives a synchronous-read instruction BRAM (1-cycle latency) with the next PC, so returned data aligns with the PC register.
- Honours load-use stalls (PcWrite, IF_ID_Write from the hazard unit) and EX-stage redirects (taken branch/jump), inserting a NOP bubble on redirect.

Parameters:
- RESET_PC, 32'h0000_0000, PC value after reset.
- NOP_INST, 32'h0000_0013, bubble instruction (addi x0,x0,0).
- IMEM_AW, 14, instruction memory word-address width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- PcWrite  in  1  1 = PC may advance; 0 = hold PC (stall).
- IF_ID_Write  in  1  1 = IF/ID register may load; 0 = hold.
- Redirect  in  1  taken branch/jump resolved in EX.
- RedirectPc  in  32  redirect target byte address.
- ImemAddr  out  IMEM_AW  word address to BRAM (combinational) = PcNext[IMEM_AW+1:2].
- ImemData  in  32  BRAM read data; mem[previous-cycle ImemAddr].
- Inst  out  32  IF/ID instruction (registered).
- PcOut  out  32  IF/ID PC of Inst (registered).
- InstValid  out  1  1 = Inst is a real fetch; 0 = bubble.
- Misaligned  out  1  registered one-cycle pulse: RedirectPc[1:0] != 0.
- FetchCount  out  32  count of instructions loaded into IF/ID with InstValid=1.

Behaviour:
- Internal Pc register; PcNext is combinational, priority order:
  - rst: RESET_PC.
  - Redirect: {RedirectPc[31:2],2'b00}.
  - !PcWrite: Pc.
  - else: Pc+4, mod 2^32 (wraps at 32'hFFFF_FFFC to 0).
- ImemAddr is always driven from PcNext, including during rst. Invariant: ImemData == mem[Pc] in every cycle after reset release. During a stall the BRAM re-reads the same word.
- On each clock edge: Pc <= PcNext.
- IF/ID register update, priority order:
  - rst: Inst=NOP_INST, PcOut=0, InstValid=0.
  - Redirect (overrides IF_ID_Write=0): Inst=NOP_INST, PcOut=Pc, InstValid=0. This flushes the wrong-path fetch.
  - !IF_ID_Write: hold Inst, PcOut, InstValid.
  - else: Inst=ImemData, PcOut=Pc, InstValid=1.
- Latency:
  - Fetch of address A appears on Inst one cycle after Pc==A.
  - First valid Inst (mem[RESET_PC]) appears on the 1st edge after rst falls, i.e. 1 cycle after release.
  - Redirect penalty is one bubble; target instruction appears 2 edges after the Redirect cycle.
- Stall/redirect coincidence: Redirect wins. Pc loads the target and IF/ID flushes even if PcWrite=IF_ID_Write=0.
- PcWrite=1 with IF_ID_Write=0 is illegal from the hazard unit. Defined behaviour: Pc advances and IF/ID holds, so the skipped instruction is lost. The bench asserts this never occurs.
- Misaligned: registered from Redirect & |RedirectPc[1:0]; reset 0. The target is still used with its low bits cleared.
- FetchCount:
  - Reset 0.
  - +1 on each edge where the "else" load case fires.
  - Wraps 2^32-1 -> 0.
  - Holds on stall and redirect.
- Reset mid-operation: all state returns to reset values on the next edge regardless of Redirect/stall inputs. No partial state is retained.

Decomposition:
- Shared constants header: RESET_PC default, NOP_INST encoding, RISC-V opcodes.
- One sub-module, pc_gen: Pc register, PcNext mux, Misaligned flag.
- IF/ID register and FetchCount live in if_stage.

Test Plan:
- Reset/sequential fetch, mem[i]=32'h1000_0000+i, rst 3 cycles then free run:
  - ImemAddr = 0,1,2... after release.
  - Inst = 32'h1000_0000, 32'h1000_0001...
  - PcOut = 0, 4, 8; InstValid=1 from cycle 1; FetchCount increments.
- Load-use stall, PcWrite=IF_ID_Write=0 for 2 cycles while Pc=0x8:
  - Inst/PcOut hold at 0x4's entry.
  - ImemAddr stays 2; Pc stays 0x8.
  - Resume yields PcOut=0x8 with no skip or duplicate.
  - FetchCount unchanged during the stall.
- Redirect at Pc=0x10 to 0x40:
  - Next Inst=NOP_INST, InstValid=0, PcOut=0x10.
  - Following Inst=mem[0x40>>2], PcOut=0x40.
- Redirect coincident with stall: Redirect=1, PcWrite=IF_ID_Write=0, target 0x80 -> flush to NOP, then PcOut=0x80.
- Misaligned redirect to 0x42 -> Misaligned=1 for exactly one cycle; fetch proceeds from 0x40.
- Wrap and reset mid-run:
  - Force Pc near 32'hFFFF_FFFC via redirect: next PcOut=0.
  - Assert rst while stalled: Pc=RESET_PC, InstValid=0, FetchCount=0 after one edge.
